// File: rtl/echo_filter_pkg.sv
// echo_pkg: shared sample type, FSM states and saturating add for the echo stage
package echo_pkg;
  localparam int SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef enum logic {FILL, RUN} state_t;
  function automatic sample_t sat_add(sample_t a, sample_t b);
    logic signed [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return (s[SAMPLE_W] != s[SAMPLE_W-1]) ? {s[SAMPLE_W], {(SAMPLE_W-1){~s[SAMPLE_W]}}} : s[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/echo_filter_delay_ram.sv
// delay_ram: simple dual-port RAM, synchronous write and registered read
module delay_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/echo_filter.sv
// echo_filter: recursive echo y[n] = sat(x[n] + (y[n-D] >>> DECAY_SHIFT)), D = 2**DEPTH_LOG2
module echo_filter
  import echo_pkg::*;
#(
  parameter int DATA_W      = SAMPLE_W,
  parameter int DEPTH_LOG2  = 12,
  parameter int DECAY_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_ready,
  input  logic                     write_ready,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] readdata,
  output logic signed [DATA_W-1:0] writedata,
  output logic                     primed
);
  logic                     s;
  state_t                   state;
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DATA_W-1:0]        rdata;
  logic signed [DATA_W-1:0] d, f, y;
  logic signed [DATA_W:0]   sum;
  assign s = read_ready & write_ready;
  // The RAM output register is the prefetch: it re-reads wr_ptr every cycle, so
  // one idle cycle after a strobe it already holds y[n-D] for the next sample.
  delay_ram #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W)) ram (
    .clk  (clk),
    .we   (s & ~reset),
    .waddr(wr_ptr),
    .wdata(y),
    .raddr(wr_ptr),
    .rdata(rdata)
  );
  always_comb begin
    d   = (state == RUN) ? $signed(rdata) : '0;
    f   = d >>> DECAY_SHIFT;
    sum = {readdata[DATA_W-1], readdata} + {f[DATA_W-1], f};
    y   = !en ? readdata
        : (sum[DATA_W] != sum[DATA_W-1]) ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}}
        : sum[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      writedata <= '0;
      primed    <= 1'b0;
      wr_ptr    <= '0;
      state     <= FILL;
    end else if (s) begin
      writedata <= y;
      wr_ptr    <= wr_ptr + 1'b1;
      if (&wr_ptr) begin
        state  <= RUN;
        primed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_echo_filter.sv
// tb_echo_filter: directed + randomized checks of echo_filter against a sample-history model
module tb_echo_filter;
  localparam int D    = 4;
  localparam int DIV  = 2;
  localparam int MAXV = 8388607;
  localparam int MINV = -8388608;
  logic clk, reset, read_ready, write_ready, en, primed;
  logic signed [23:0] readdata, writedata;
  int hist[$];
  int checks = 0;
  int passed = 0;
  int imp[13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
  echo_filter #(.DATA_W(24), .DEPTH_LOG2(2), .DECAY_SHIFT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_ready (read_ready),
    .write_ready(write_ready),
    .en         (en),
    .readdata   (readdata),
    .writedata  (writedata),
    .primed     (primed)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  function automatic int model(input int x, input bit e);
    int dly, fb, sum, y;
    dly = (hist.size() >= D) ? hist[hist.size()-D] : 0;
    fb  = (dly >= 0) ? dly / DIV : -((-dly + DIV - 1) / DIV);
    sum = x + fb;
    y   = !e ? x : (sum > MAXV) ? MAXV : (sum < MINV) ? MINV : sum;
    hist.push_back(y);
    return y;
  endfunction
  task automatic strobe(input int x, input bit e);
    int exp_y;
    @(negedge clk);
    readdata = 24'(x); en = e; read_ready = 1; write_ready = 1;
    @(negedge clk);
    read_ready = 0; write_ready = 0; readdata = 24'($urandom);
    exp_y = model(x, e);
    check("wdata", writedata, exp_y);
    check("primed", primed, int'(hist.size() >= D));
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset(input bit with_strobe);
    @(negedge clk);
    reset = 1; read_ready = with_strobe; write_ready = with_strobe; readdata = 24'($urandom);
    @(negedge clk);
    reset = 0; read_ready = 0; write_ready = 0;
    hist.delete();
    check("rst_wdata", writedata, 0);
    check("rst_primed", primed, 0);
    @(negedge clk);
  endtask
  initial begin
    int x, w, p;
    reset = 1; read_ready = 0; write_ready = 0; en = 1; readdata = '0;
    repeat (2) @(negedge clk);
    do_reset(0);
    // impulse response against fixed expectations
    for (int i = 0; i < 13; i++) begin
      strobe(i == 0 ? 1000 : 0, 1);
      check("impulse", writedata, imp[i]);
      check("primed_4th", primed, int'(i >= 3));
    end
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      strobe(8388592, 1);
      check("pos_sat", writedata, i < 4 ? 8388592 : MAXV);
    end
    do_reset(0);
    for (int i = 0; i < 9; i++) strobe(i == 0 ? -1001 : 0, 1);
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      strobe(MINV, 1);
      check("neg_sat", writedata, MINV);
    end
    // handshake gating: only one ready high must freeze everything
    w = hist[$]; p = int'(hist.size() >= D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      read_ready = (i < 10); write_ready = (i >= 10); readdata = 24'($urandom);
      check("gate_wdata", writedata, w);
      check("gate_primed", primed, p);
    end
    @(negedge clk);
    read_ready = 0; write_ready = 0;
    for (int i = 0; i < 6; i++) strobe(int'($urandom_range(0, 4000)) - 2000, 1);
    do_reset(0);
    for (int i = 1; i <= 5; i++) begin
      strobe(10 * i, 0);
      check("bypass", writedata, 10 * i);
    end
    for (int i = 0; i < 4; i++) strobe(0, 1);
    for (int i = 0; i < 6; i++) strobe(1000, 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      x = int'($urandom_range(0, 2000)) - 1000;
      strobe(x, 1);
      check("post_rst_dry", writedata, x);
    end
    // randomized mix of ranges, en toggling and occasional resets
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: x = MAXV - int'($urandom_range(0, 100));
        1: x = MINV + int'($urandom_range(0, 100));
        2: x = int'($urandom_range(0, 20000)) - 10000;
        default: x = int'(24'($urandom)) - ((int'(24'($urandom)) >= 0) ? 0 : 0);
      endcase
      if (x > MAXV || x < MINV) x = int'($signed(24'(x)));
      if ($urandom_range(0, 39) == 0) do_reset(1'($urandom));
      strobe(x, $urandom_range(0, 3) != 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
